reram_pulse_seq: RTL and testbench
==================================

RERAM_PULSE_SEQ -- requirements
Module: reram_pulse_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, sets the Vref precharge duration in clocks before a SET or RESET pulse; legal range 1..255.
REQ-002 SHALL have parameter DEAD_CYCLES, default 2, sets the all-switches-open gap between any two switch phases; legal range 1..255.
REQ-003 SHALL have parameter WIDTH_W, default 8, sets the width of the pulse-width field.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port cmd_valid_i, input, 1 bit: command request.
REQ-007 SHALL have port cmd_ready_o, output, 1 bit: command accept.
REQ-008 SHALL have port cmd_op_i, input, 2 bits: 00 READ, 01 SET, 10 RESET, 11 illegal.
REQ-009 SHALL have port cmd_width_i, input, WIDTH_W bits: pulse width in clocks.
REQ-010 SHALL have port sw_ref_o, output, 1 bit: drives the column-driver SWref switch.
REQ-011 SHALL have port sw_c_plus_o, output, 1 bit: drives the SWc_plus switch.
REQ-012 SHALL have port sw_c_minus_o, output, 1 bit: drives the SWc_minus switch.
REQ-013 SHALL have port busy_o, output, 1 bit: high whenever the sequencer is not in IDLE.
REQ-014 SHALL have port done_o, output, 1 bit: one-cycle pulse marking sequence completion.
REQ-015 SHALL have port err_o, output, 1 bit: one-cycle pulse flagging a rejected or aborted command.

Function
REQ-016 FSM states SHALL be IDLE, PRECHARGE, DEAD1, PULSE, DEAD2 and DONE; all outputs SHALL be registered.
REQ-017 cmd_ready_o SHALL be 1 only in IDLE; a command is accepted on the cycle where cmd_valid_i and cmd_ready_o are both 1, and cmd_op_i and cmd_width_i SHALL be latched on that cycle.
REQ-018 An illegal op (11) or a cmd_width_i of 0 SHALL produce a 1-cycle err_o pulse on the cycle after acceptance, cause no switch activity and no done_o, and leave the FSM in IDLE.
REQ-019 SET and RESET, with acceptance at cycle 0 and width W, SHALL run as follows:
- sw_ref_o high in cycles 1..S (S = SETTLE_CYCLES);
- all switches low for D cycles (D = DEAD_CYCLES);
- sw_c_plus_o (SET) or sw_c_minus_o (RESET) high for W cycles;
- all switches low for D cycles;
- done_o high at cycle S+2D+W+1.
REQ-020 READ SHALL drive sw_ref_o high in cycles 1..W, then hold all switches low for D cycles, then pulse done_o at cycle W+D+1.
REQ-021 At most one switch output SHALL be high in any cycle, and every change from one switch to another SHALL be separated by at least D all-low cycles.
REQ-022 In the DONE cycle, done_o=1, busy_o=0 and cmd_ready_o=1; a new command MAY be accepted in the DONE cycle, giving back-to-back operation.
REQ-023 Phase timing SHALL use one down-counter of width max(8, WIDTH_W); a phase ends when the counter reaches 1, and the counter SHALL never wrap.

Reset
REQ-024 While wb_rst_i=1, the FSM SHALL be held in IDLE at the next edge, all switch outputs, busy_o, done_o and err_o SHALL be 0, cmd_ready_o SHALL be 1, and the counter SHALL be 0.
REQ-025 Reset asserted mid-pulse SHALL open every switch on the following edge, with no dead-time sequence and no done_o.

Configuration
REQ-026 When RERAM_SEQ_ABORT_EN is defined, an input port abort_i (1 bit) SHALL exist with the following behaviour:
- in PRECHARGE, DEAD1 or PULSE, abort_i=1 SHALL clear all switches on the next edge and move the FSM to DEAD2;
- DEAD2 SHALL run its full D cycles;
- DONE SHALL then assert done_o and err_o together;
- abort_i SHALL be ignored in IDLE, DEAD2 and DONE.
REQ-027 When RERAM_SEQ_ABORT_EN is undefined, abort_i SHALL be absent and every sequence SHALL run to completion.

Structure
REQ-028 Package reram_seq_pkg SHALL hold:
- the op encoding enum;
- the FSM state enum;
- the default constants for SETTLE_CYCLES, DEAD_CYCLES and WIDTH_W.
REQ-029 Sub-module reram_seq_timer SHALL be a loadable down-counter that outputs a last-cycle flag; it SHALL be instantiated once.

Verification
REQ-030 SET with W=3 and defaults: sw_ref_o high in cycles 1-4, low in 5-6, sw_c_plus_o high in 7-9, low in 10-11, done_o at cycle 12.
REQ-031 READ with W=5: sw_ref_o high in cycles 1-5, low in 6-7, done_o at cycle 8, and sw_c_plus_o and sw_c_minus_o stay 0 throughout.
REQ-032 Op=11, and separately W=0: err_o pulses at cycle 1, all switches stay 0, there is no done_o, and cmd_ready_o=1 at cycle 1.
REQ-033 wb_rst_i asserted in cycle 8 of a RESET with W=10: all outputs are 0 at cycle 9 and cmd_ready_o=1 at cycle 9.
REQ-034 With RERAM_SEQ_ABORT_EN defined, abort_i in cycle 8 of a SET with W=10: switches low from cycle 9 for 2 cycles, then done_o and err_o both high at cycle 11.
REQ-035 Back-to-back: cmd_valid_i held high with SET W=1 then RESET W=1: the second command is accepted in the first command's DONE cycle, and a one-hot assertion checker reports no overlap.

Source files
------------

// File: rtl/reram_seq_pkg.sv
// Shared encodings and default timing constants for the ReRAM pulse sequencer.
package reram_seq_pkg;

    localparam int SETTLE_CYCLES_DEF = 4;
    localparam int DEAD_CYCLES_DEF   = 2;
    localparam int WIDTH_W_DEF       = 8;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_SET     = 2'b01,
        OP_RESET   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_DEAD1     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_DEAD2     = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic cmd_rejected(input logic [1:0] op, input logic zero_width);
        return (op == OP_ILLEGAL) || zero_width;
    endfunction

endpackage

// File: rtl/reram_seq_sw_chk.sv
// Switch-safety checker: at most one switch closed, and at least DEAD_CYCLES open cycles between different switches.
module reram_seq_sw_chk #(
    parameter int DEAD_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    input logic sw_ref,
    input logic sw_c_plus,
    input logic sw_c_minus
);

    localparam logic [8:0] DEAD_L = 9'(DEAD_CYCLES);

    logic [2:0] sw_s;
    logic [2:0] last_r;
    logic [8:0] gap_r;

    assign sw_s = {sw_c_minus, sw_c_plus, sw_ref};

    // Remember the last closed switch and how long everything has been open since.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 3'b000;
            gap_r  <= 9'd0;
        end else if (sw_s != 3'b000) begin
            last_r <= sw_s;
            gap_r  <= 9'd0;
        end else if (gap_r != 9'h1ff) begin
            gap_r  <= gap_r + 9'd1;
        end else begin
            gap_r  <= gap_r;
        end
    end

    // Overlap and dead-time properties.
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(sw_s));
            if ((sw_s != 3'b000) && (last_r != 3'b000) && (sw_s != last_r)) begin
                assert (gap_r >= DEAD_L);
            end
        end
    end

endmodule

// File: rtl/reram_seq_timer.sv
// Loadable saturating down-counter; last is high while the count equals 1.
module reram_seq_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          last
);

    logic [CW-1:0] count_r;

    // Count register: load wins, otherwise decrement and stop at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != '0) begin
            count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign last = (count_r == {{(CW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/reram_pulse_seq.sv
// ReRAM column-driver pulse sequencer: precharge, dead time, SET/RESET pulse, dead time, done.
// Optional abort input enabled by defining RERAM_SEQ_ABORT_EN.
module reram_pulse_seq
    import reram_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int DEAD_CYCLES   = DEAD_CYCLES_DEF,
    parameter int WIDTH_W       = WIDTH_W_DEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
`ifdef RERAM_SEQ_ABORT_EN
    input  logic               abort_i,
`endif
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [WIDTH_W-1:0] cmd_width_i,
    output logic               sw_ref_o,
    output logic               sw_c_plus_o,
    output logic               sw_c_minus_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int CW = max_int(8, WIDTH_W);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] DEAD_LD   = CW'(DEAD_CYCLES);

    state_e               state_r, state_next;
    op_e                  op_r, op_next;
    logic [WIDTH_W-1:0]   width_r;
    logic                 tmr_load_s;
    logic [CW-1:0]        tmr_val_s;
    logic                 tmr_last_s;
    logic                 accept_s, reject_s, abort_s, abort_go_s;
    logic                 abort_pend_r;
    logic                 sw_ref_r, sw_c_plus_r, sw_c_minus_r;
    logic                 busy_r, done_r, err_r, ready_r;

`ifdef RERAM_SEQ_ABORT_EN
    assign abort_s = abort_i;
`else
    assign abort_s = 1'b0;
`endif

    reram_seq_timer #(.CW(CW)) u_timer (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .last     (tmr_last_s)
    );

    // Next-state, phase-counter load and command accept/reject decode.
    always_comb begin
        state_next = state_r;
        op_next    = op_r;
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        accept_s   = 1'b0;
        reject_s   = 1'b0;
        abort_go_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (cmd_valid_i && ready_r) begin
                    if (cmd_rejected(cmd_op_i, cmd_width_i == '0)) begin
                        reject_s   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        accept_s   = 1'b1;
                        op_next    = op_e'(cmd_op_i);
                        state_next = ST_PRECHARGE;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = (op_e'(cmd_op_i) == OP_READ) ? CW'(cmd_width_i) : SETTLE_LD;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_PRECHARGE, ST_DEAD1, ST_PULSE: begin
                if (abort_s) begin
                    abort_go_s = 1'b1;
                    state_next = ST_DEAD2;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = DEAD_LD;
                end else if (tmr_last_s) begin
                    tmr_load_s = 1'b1;
                    if (state_r == ST_DEAD1) begin
                        state_next = ST_PULSE;
                        tmr_val_s  = CW'(width_r);
                    end else if ((state_r == ST_PRECHARGE) && (op_r != OP_READ)) begin
                        state_next = ST_DEAD1;
                        tmr_val_s  = DEAD_LD;
                    end else begin
                        // READ skips the pulse: its Vref phase is the sense window.
                        state_next = ST_DEAD2;
                        tmr_val_s  = DEAD_LD;
                    end
                end else begin
                    state_next = state_r;
                end
            end
            ST_DEAD2: begin
                if (tmr_last_s) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_DEAD2;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs are decoded from the next state so they align with it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_READ;
            width_r      <= '0;
            abort_pend_r <= 1'b0;
            sw_ref_r     <= 1'b0;
            sw_c_plus_r  <= 1'b0;
            sw_c_minus_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            state_r <= state_next;
            op_r    <= op_next;
            if (accept_s) begin
                width_r      <= cmd_width_i;
                abort_pend_r <= 1'b0;
            end else if (abort_go_s) begin
                abort_pend_r <= 1'b1;
            end else begin
                abort_pend_r <= abort_pend_r;
            end
            sw_ref_r     <= (state_next == ST_PRECHARGE);
            sw_c_plus_r  <= (state_next == ST_PULSE) && (op_next == OP_SET);
            sw_c_minus_r <= (state_next == ST_PULSE) && (op_next == OP_RESET);
            busy_r       <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            ready_r      <= (state_next == ST_IDLE) || (state_next == ST_DONE);
            done_r       <= (state_next == ST_DONE);
            err_r        <= reject_s || ((state_next == ST_DONE) && abort_pend_r);
        end
    end

    assign cmd_ready_o  = ready_r;
    assign sw_ref_o     = sw_ref_r;
    assign sw_c_plus_o  = sw_c_plus_r;
    assign sw_c_minus_o = sw_c_minus_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_reram_pulse_seq.sv
// Scoreboard bench for reram_pulse_seq: cycle-indexed expected-output timeline plus a done/err event queue.
module tb_reram_pulse_seq;
    import reram_seq_pkg::*;

    localparam int S = 4;
    localparam int D = 2;
    localparam int N = 8192;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [1:0] op;
    logic [7:0] width;
    logic       ready, sw_ref, sw_plus, sw_minus, busy, done, err;
`ifdef RERAM_SEQ_ABORT_EN
    logic       abort;
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    reram_pulse_seq #(.SETTLE_CYCLES(S), .DEAD_CYCLES(D), .WIDTH_W(8)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
`ifdef RERAM_SEQ_ABORT_EN
        .abort_i      (abort),
`endif
        .cmd_valid_i  (valid),
        .cmd_ready_o  (ready),
        .cmd_op_i     (op),
        .cmd_width_i  (width),
        .sw_ref_o     (sw_ref),
        .sw_c_plus_o  (sw_plus),
        .sw_c_minus_o (sw_minus),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    reram_seq_sw_chk #(.DEAD_CYCLES(D)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .sw_ref     (sw_ref),
        .sw_c_plus  (sw_plus),
        .sw_c_minus (sw_minus)
    );

    typedef struct { int cyc; bit done; bit err; } ev_t;
    ev_t evq[$];

    logic [2:0] exp_sw [N];
    bit exp_busy [N];
    bit exp_rdy  [N];
    bit exp_done [N];
    bit exp_err  [N];
    bit rst_at   [N];
    bit abort_at [N];

    int cyc = 0;
    int free_c;
    int last_acc;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rst = 1'b1;
        forever begin
            @(posedge clk); #1;
            rst = rst_at[cyc];
        end
    end

`ifdef RERAM_SEQ_ABORT_EN
    initial begin
        abort = 1'b0;
        forever begin
            @(posedge clk); #1;
            abort = abort_at[cyc];
        end
    end
`endif

    function automatic void clear_from(input int c0);
        for (int c = c0; c < N; c++) begin
            exp_sw[c] = 3'b000; exp_busy[c] = 1'b0; exp_rdy[c] = 1'b1;
            exp_done[c] = 1'b0; exp_err[c] = 1'b0;
        end
    endfunction

    // Reference model: timeline of one command accepted in cycle a.
    function automatic void model_cmd(input int a, input logic [1:0] o, input int w, input int abort_rel);
        int ref_e, pul_s, pul_e, act_end, e, cut;
        bit ab;
        logic [2:0] pbit;
        if (o == 2'b11 || w == 0) begin
            exp_err[a+1] = 1'b1;
            evq.push_back('{a+1, 1'b0, 1'b1});
            free_c = a + 1;
            return;
        end
        if (o == 2'b00) begin
            ref_e = a + w; pul_s = 1; pul_e = 0; act_end = a + w;
            e = a + w + D + 1;
        end else begin
            ref_e = a + S; pul_s = a + S + D + 1; pul_e = a + S + D + w; act_end = pul_e;
            e = pul_e + D + 1;
        end
        pbit = (o == 2'b01) ? 3'b010 : 3'b100;
        ab = ABORT_EN && abort_rel >= 1 && (a + abort_rel) <= act_end;
        if (ABORT_EN && abort_rel >= 1 && (a + abort_rel) <= e) abort_at[a+abort_rel] = 1'b1;
        cut = ab ? a + abort_rel : act_end;
        if (ab) e = cut + D + 1;
        for (int c = a + 1; c < e; c++) begin
            exp_busy[c] = 1'b1; exp_rdy[c] = 1'b0;
            if (c <= ref_e && c <= cut) exp_sw[c] = 3'b001;
            if (c >= pul_s && c <= pul_e && c <= cut) exp_sw[c] = pbit;
        end
        exp_done[e] = 1'b1;
        exp_err[e] = ab;
        evq.push_back('{e, 1'b1, ab});
        free_c = e;
    endfunction

    function automatic void reset_at(input int r);
        ev_t keep[$];
        rst_at[r] = 1'b1;
        clear_from(r + 1);
        foreach (evq[i]) if (evq[i].cyc <= r) keep.push_back(evq[i]);
        evq = keep;
        free_c = r + 1;
    endfunction

    task automatic issue(input logic [1:0] o, input int w, input int gap, input int abort_rel);
        int target;
        target = free_c + gap;
        while (cyc < target) begin
            if (!exp_rdy[cyc]) begin
                valid = 1'($urandom_range(0, 1));
                op    = 2'($urandom_range(0, 3));
                width = 8'($urandom_range(0, 255));
            end else begin
                valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        valid = 1'b1; op = o; width = 8'(w);
        last_acc = cyc;
        model_cmd(cyc, o, w, abort_rel);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Monitor: compare every cycle's outputs to the timeline; pop the queue on done/err.
    initial begin
        ev_t ev;
        logic [6:0] got, expv;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                got  = {sw_minus, sw_plus, sw_ref, busy, ready, done, err};
                expv = {exp_sw[cyc], exp_busy[cyc], exp_rdy[cyc], exp_done[cyc], exp_err[cyc]};
                checks++;
                if (got !== expv) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got(mi,pl,ref,busy,rdy,done,err)=%b exp=%b", cyc, got, expv);
                end
                checks++;
                if ($countones({sw_minus, sw_plus, sw_ref}) > 1) begin
                    errors++;
                    $display("FAIL onehot cyc=%0d got=%b exp=at most one high", cyc, {sw_minus, sw_plus, sw_ref});
                end
                if (done === 1'b1 || err === 1'b1) begin
                    checks++;
                    if (evq.size() == 0) begin
                        errors++;
                        $display("FAIL event cyc=%0d got done=%b err=%b exp=no event", cyc, done, err);
                    end else begin
                        ev = evq.pop_front();
                        if (ev.cyc != cyc || ev.done != done || ev.err != err) begin
                            errors++;
                            $display("FAIL event got cyc=%0d done=%b err=%b exp cyc=%0d done=%b err=%b",
                                     cyc, done, err, ev.cyc, ev.done, ev.err);
                        end
                    end
                end
            end
        end
    end

    initial begin
        wait (cyc >= 20000);
        $display("FAIL watchdog cyc=%0d exp=finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, ab;
        for (int c = 0; c < N; c++) begin
            rst_at[c] = 1'b0; abort_at[c] = 1'b0;
        end
        clear_from(0);
        rst_at[0] = 1'b1; rst_at[1] = 1'b1; rst_at[2] = 1'b1;
        free_c = 3;
        valid = 1'b0; op = 2'b00; width = 8'd0;
        @(posedge clk); #1;

        issue(2'b01, 3, 0, 0);     // SET W=3
        issue(2'b00, 5, 1, 0);     // READ W=5
        issue(2'b11, 5, 1, 0);     // illegal op
        issue(2'b01, 0, 0, 0);     // zero width
        issue(2'b01, 1, 0, 0);     // back-to-back SET W=1 ...
        issue(2'b10, 1, 0, 0);     // ... then RESET W=1 in the DONE cycle
        issue(2'b00, 255, 0, 0);   // widest READ
        issue(2'b10, 10, 1, 0);    // RESET W=10 interrupted by reset
        reset_at(last_acc + 8);
        if (ABORT_EN) issue(2'b01, 10, 1, 8);
        for (int i = 0; i < 40; i++) begin
            w  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0;
            issue(2'($urandom_range(0, 3)), w, int'($urandom_range(0, 2)), ab);
        end
        while (cyc < free_c + 4) begin
            @(posedge clk); #1;
        end
        checks++;
        if (evq.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d exp=0", evq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
